// File: rtl/div_share_sched.sv
// div_share_sched: round-robin scheduler that shares one radix-2 restoring
// divider among NUM_LANES SIMD lanes. Each result is tagged with the index of the granted lane.
module div_share_sched #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_LANES  = 4,
    parameter int LANE_BITS  = $clog2(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_LANES-1:0]            req,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rm_flat,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rn_flat,
    output logic [NUM_LANES-1:0]            grant,
    output logic                            busy,
    output logic [NUM_LANES-1:0]            done,
    output logic [LANE_BITS-1:0]            result_lane,
    output logic [DATA_WIDTH-1:0]           quotient,
    output logic [DATA_WIDTH-1:0]           remainder,
    output logic                            div_by_zero
);
    localparam int CNT_BITS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                state;
    logic [LANE_BITS-1:0]  rr_ptr;
    logic [LANE_BITS-1:0]  lane;
    logic [CNT_BITS-1:0]   cnt;
    logic [DATA_WIDTH-1:0] dvd;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] divisor;

    logic [LANE_BITS-1:0]  sel;
    logic [LANE_BITS-1:0]  cand;
    logic                  found;
    logic [LANE_BITS-1:0]  next_ptr;
    logic [DATA_WIDTH-1:0] sel_rm;
    logic [DATA_WIDTH-1:0] sel_rn;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] sub;

    // First requesting lane at or after rr_ptr, wrapping around.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = LANE_BITS'((int'(rr_ptr) + k) % NUM_LANES);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign next_ptr = (sel == LANE_BITS'(NUM_LANES - 1)) ? '0 : sel + LANE_BITS'(1);
    assign sel_rm   = rm_flat[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_rn   = rn_flat[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    // The partial remainder is always below the divisor, so the difference fits in DATA_WIDTH bits.
    assign shifted = {rem, dvd[DATA_WIDTH-1]};
    assign sub     = shifted[DATA_WIDTH-1:0] - divisor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            lane        <= '0;
            cnt         <= '0;
            dvd         <= '0;
            rem         <= '0;
            divisor     <= '0;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
            result_lane <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            grant <= '0;
            done  <= '0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (enable && found) begin
                        grant   <= NUM_LANES'(1) << sel;
                        busy    <= 1'b1;
                        lane    <= sel;
                        dvd     <= sel_rm;
                        divisor <= sel_rn;
                        rem     <= '0;
                        cnt     <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= (sel_rn == '0) ? S_DONE : S_ITER;
                    end
                end
                S_ITER: begin
                    if (enable) begin
                        if (shifted >= {1'b0, divisor}) begin
                            rem <= sub;
                            dvd <= {dvd[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[DATA_WIDTH-1:0];
                            dvd <= {dvd[DATA_WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_BITS'(1);
                        if (cnt == CNT_BITS'(DATA_WIDTH - 1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A zero divisor skips iteration, so dvd still holds the dividend here.
                    done        <= NUM_LANES'(1) << lane;
                    result_lane <= lane;
                    div_by_zero <= (divisor == '0);
                    quotient    <= (divisor == '0) ? '1 : dvd;
                    remainder   <= (divisor == '0) ? dvd : rem;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: vector table, hand-written corner sequences and randomized
// traffic for div_share_sched, checked against an arithmetic reference model.
module tb_div_share_sched;
    localparam int W  = 64;
    localparam int N  = 4;
    localparam int LB = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   req;
    logic [N*W-1:0] rm_flat;
    logic [N*W-1:0] rn_flat;
    logic [N-1:0]   grant;
    logic           busy;
    logic [N-1:0]   done;
    logic [LB-1:0]  result_lane;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    typedef struct {
        int         lane;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t         vecs[6];
    int           rr_exp[5] = '{0, 1, 2, 3, 0};
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           grant_cycle = 0;
    int           done_cycle = 0;
    int           last_done;
    int           model_ptr = 0;
    int           g;
    int           exp_lane;
    int           seen;
    logic [N-1:0] pend;
    logic [W-1:0] op_a[N];
    logic [W-1:0] op_b[N];
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;

    div_share_sched #(.DATA_WIDTH(W), .NUM_LANES(N)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .req(req),
        .rm_flat(rm_flat),
        .rn_flat(rn_flat),
        .grant(grant),
        .busy(busy),
        .done(done),
        .result_lane(result_lane),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        if (b == '0) begin
            q = '1;
            r = a;
            dz = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            dz = 1'b0;
        end
    endfunction

    function automatic int ref_pick(input int ptr, input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic apply_stimulus(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
        rm_flat[lane*W +: W] = a;
        rn_flat[lane*W +: W] = b;
        req[lane] = 1'b1;
    endtask

    task automatic add_random_req(input int lane);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = {$urandom, $urandom} >> $urandom_range(0, 40);
        case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 1000));
            3:       b = {$urandom, $urandom};
            default: b = {$urandom, $urandom} >> $urandom_range(1, 63);
        endcase
        op_a[lane] = a;
        op_b[lane] = b;
        pend[lane] = 1'b1;
        apply_stimulus(lane, a, b);
    endtask

    task automatic wait_grant(output int lane_seen);
        lane_seen = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                grant_cycle = cyc;
                for (int i = N - 1; i >= 0; i--) begin
                    if (grant[i]) lane_seen = i;
                end
                return;
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL grant_timeout actual=none required=grant");
    endtask

    task automatic wait_done();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done != '0) begin
                done_cycle = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL done_timeout actual=none required=done");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
    endtask

    task automatic run_single(input string tag, input int lane, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic dz, input int lat);
        int gl;
        apply_stimulus(lane, a, b);
        wait_grant(gl);
        req[lane] = 1'b0;
        check_output({tag, "_grant"}, grant, N'(1) << lane);
        check_output({tag, "_busy_grant"}, busy, 1'b1);
        wait_done();
        check_output({tag, "_latency"}, done_cycle - grant_cycle, lat);
        check_output({tag, "_done"}, done, N'(1) << lane);
        check_output({tag, "_q"}, quotient, q);
        check_output({tag, "_r"}, remainder, r);
        check_output({tag, "_dz"}, div_by_zero, dz);
        check_output({tag, "_lane"}, result_lane, lane);
        check_output({tag, "_busy_done"}, busy, 1'b1);
        @(negedge clk);
        check_output({tag, "_q_hold"}, quotient, q);
        check_output({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        req = '0;
        rm_flat = '0;
        rn_flat = '0;
        repeat (2) @(negedge clk);
        check_output("rst_grant", grant, '0);
        check_output("rst_done", done, '0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_q", quotient, '0);
        check_output("rst_r", remainder, '0);
        check_output("rst_dz", div_by_zero, 1'b0);
        check_output("rst_lane", result_lane, '0);
        rst = 1'b1;
        enable = 1'b1;

        // Vector table: single-lane transactions with hand-computed results.
        vecs[0] = '{0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65};
        vecs[1] = '{2, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1};
        vecs[2] = '{3, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 65};
        vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65};
        vecs[4] = '{0, 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65};
        vecs[5] = '{2, 64'hDEAD_BEEF_0000_0000, 64'h1_0000, 64'h0000_DEAD_BEEF_0000, 64'd0, 1'b0, 65};
        for (int v = 0; v < 6; v++) begin
            run_single($sformatf("vec%0d", v), vecs[v].lane, vecs[v].a, vecs[v].b,
                       vecs[v].q, vecs[v].r, vecs[v].dz, vecs[v].lat);
        end

        // All lanes requesting from reset, each re-requesting after its grant.
        do_reset();
        for (int i = 0; i < N; i++) apply_stimulus(i, 64'd1000 + 64'(i * 37), 64'(i + 3));
        last_done = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            if (g < 0) break;
            check_output($sformatf("rr_grant%0d", k), grant, N'(1) << rr_exp[k]);
            if (k > 0) check_output($sformatf("rr_gap%0d", k), grant_cycle - last_done, 1);
            req[g] = 1'b0;
            @(negedge clk);
            if (k < 4) req[g] = 1'b1;
            else req = '0;
            ref_div(64'd1000 + 64'(g * 37), 64'(g + 3), eq, er, edz);
            wait_done();
            last_done = done_cycle;
            check_output($sformatf("rr_done%0d", k), done, N'(1) << g);
            check_output($sformatf("rr_q%0d", k), quotient, eq);
            check_output($sformatf("rr_r%0d", k), remainder, er);
        end

        // enable low for 10 cycles during iteration stretches latency by 10.
        apply_stimulus(1, 64'd1000, 64'd33);
        wait_grant(g);
        req[1] = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done != '0 || busy != 1'b1) seen++;
        end
        enable = 1'b1;
        check_output("freeze_quiet", seen, 0);
        wait_done();
        check_output("freeze_latency", done_cycle - grant_cycle, 75);
        check_output("freeze_q", quotient, 64'd30);
        check_output("freeze_r", remainder, 64'd10);

        // enable low in IDLE holds off the grant.
        @(negedge clk);
        enable = 1'b0;
        apply_stimulus(1, 64'd77, 64'd7);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (grant != '0 || busy != 1'b0) seen++;
        end
        check_output("idle_hold", seen, 0);
        enable = 1'b1;
        wait_grant(g);
        req[1] = 1'b0;
        check_output("idle_grant", grant, 4'b0010);
        wait_done();
        check_output("idle_q", quotient, 64'd11);
        check_output("idle_latency", done_cycle - grant_cycle, 65);

        // Reset mid-iteration aborts the operation silently.
        apply_stimulus(0, 64'h0123_4567_89AB_CDEF, 64'd3);
        wait_grant(g);
        req[0] = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_q", quotient, '0);
        check_output("abort_r", remainder, '0);
        check_output("abort_done", done, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done != '0 || busy != 1'b0) seen++;
        end
        check_output("abort_no_done", seen, 0);
        run_single("after_abort", 1, 64'd50, 64'd5, 64'd10, 64'd0, 1'b0, 65);

        // Randomized multi-lane traffic against the reference model.
        do_reset();
        pend = '0;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) add_random_req(i);
            end
            if (pend == '0) add_random_req(int'($urandom_range(0, N - 1)));
            exp_lane = ref_pick(model_ptr, pend);
            wait_grant(g);
            if (g < 0) break;
            check_output($sformatf("rand_grant%0d", n), grant, N'(1) << exp_lane);
            req[g] = 1'b0;
            pend[g] = 1'b0;
            model_ptr = (exp_lane + 1) % N;
            ref_div(op_a[g], op_b[g], eq, er, edz);
            wait_done();
            check_output($sformatf("rand_latency%0d", n), done_cycle - grant_cycle,
                         (op_b[g] == '0) ? 1 : W + 1);
            check_output($sformatf("rand_done%0d", n), done, N'(1) << g);
            check_output($sformatf("rand_lane%0d", n), result_lane, g);
            check_output($sformatf("rand_q%0d", n), quotient, eq);
            check_output($sformatf("rand_r%0d", n), remainder, er);
            check_output($sformatf("rand_dz%0d", n), div_by_zero, edz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Scheduler plus iterative engine that shares one unsigned radix-2 restoring divider among the ALU lanes of a SIMD unit.
- Per-lane combinational dividers are too costly, so lanes post DIV requests here.
- A round-robin arbiter grants one lane at a time. The divider runs DATA_WIDTH iterations, then returns quotient/remainder tagged with the lane index.

Parameters:
- DATA_WIDTH, 64, operand/result width in bits.
- NUM_LANES, 4, number of requesting ALU lanes (>=2).
- LANE_BITS, $clog2(NUM_LANES), width of the lane index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  high = may issue grants and advance iterations; low = freeze.
- req  input  NUM_LANES  per-lane request level.
- rm_flat  input  NUM_LANES*DATA_WIDTH  dividends; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- rn_flat  input  NUM_LANES*DATA_WIDTH  divisors, same packing.
- grant  output  NUM_LANES  one-hot, 1-cycle pulse; operands captured this cycle.
- busy  output  1  high from the grant cycle until the done cycle, inclusive.
- done  output  NUM_LANES  one-hot, 1-cycle pulse; result valid.
- result_lane  output  LANE_BITS  lane index of the current/last result.
- quotient  output  DATA_WIDTH  result quotient.
- remainder  output  DATA_WIDTH  result remainder.
- div_by_zero  output  1  high with done when the divisor was 0.

Behaviour:
- Reset (rst low, async): state=IDLE; rr_ptr=0; grant, done, busy, div_by_zero, quotient, remainder, result_lane all 0.
- States:
  - IDLE: if enable && |req, select the first asserted lane searching from rr_ptr upward with wrap. Assert grant[sel] (registered, visible the cycle after selection) and capture rm/rn of sel. Set rr_ptr=sel+1 mod NUM_LANES. Go to ITER, or to DONE if the divisor is 0.
  - ITER: counter 0..DATA_WIDTH-1. Each enabled cycle: shift {rem,dividend} left 1; if rem>=divisor, subtract and set quotient bit. After DATA_WIDTH iterations go to DONE.
  - DONE: pulse done[lane] for 1 cycle; update quotient, remainder, result_lane, div_by_zero; return to IDLE.
- Latency: grant in cycle T, done in cycle T+DATA_WIDTH+1 (enable held high). Divide-by-zero: done in T+1.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
- Results hold until the next done. div_by_zero clears on the next non-zero done.
- Handshake:
  - Requester holds req and operands until it sees grant, then must deassert req the cycle after grant.
  - req still high after that cycle is treated as a new request.
  - req dropped before grant: the lane is not considered; no state change.
- Fairness: a lane granted is lowest priority next arbitration. Any continuously requesting lane is served within NUM_LANES grants.
- Back-to-back operation: the next grant may occur in the cycle after done, never in the same cycle. Max throughput is 1 op per DATA_WIDTH+2 cycles.
- enable low:
  - IDLE: no grant.
  - ITER: counter and datapath frozen.
  - DONE: the done pulse still fires (no stall of the output pulse).
- Operands are treated as unsigned. Widths are exact; no overflow is possible.
- Async reset mid-operation aborts the division with no done pulse. Requesters must re-request.

Test Plan:
- DATA_WIDTH=64, lane0 req rm=100 rn=7 -> grant=0001 at T; done=0001 at T+65; quotient=14, remainder=2, div_by_zero=0, result_lane=0.
- All 4 lanes requesting continuously from reset, each re-requesting after service -> grants in order lane0,1,2,3,0. Each done carries the matching lane's q/r; no lane is starved.
- lane2 rm=0x1234 rn=0 -> done=0100 at T+1; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1. Next op 9/3 -> q=3, r=0, div_by_zero=0.
- rm=0xFFFF_FFFF_FFFF_FFFF rn=1 -> quotient all ones, remainder 0. rm=5 rn=9 -> q=0, r=5.
- enable low for 10 cycles mid-ITER -> done delayed by exactly 10 cycles, result unchanged. enable low in IDLE with req=0010 -> no grant until enable returns high.
- rst asserted at iteration 30 -> all outputs 0 immediately, no done. After release, lane1 request 50/5 -> q=10, r=0; first grant goes to lane1.
